// File: rtl/shift_from_msb_denorm_pkg.sv
// shift_from_msb_denorm_pkg: widths, pipeline stage types and the sticky-collecting shift step.
package shift_from_msb_denorm_pkg;
    localparam int SIG_W = 24;
    localparam int SA_W = 5;
    localparam int TAG_W = 4;
    localparam int EXT_W = SIG_W + 2;
    localparam logic [EXT_W-1:0] EXT_ONE = 1;

    typedef struct packed {
        logic [SIG_W-1:0] data;
        logic [2:0] sa_rem;
        logic [1:0] ext2;
        logic sticky;
        logic [TAG_W-1:0] tag;
    } stage_t;

    typedef struct packed {
        logic [SIG_W-1:0] trunc;
        logic guard;
        logic sticky;
        logic [TAG_W-1:0] tag;
    } fin_t;

    // Shifts {data, ext2} right by k when en, folding every bit that falls off the extension into sticky.
    function automatic stage_t shift_step(stage_t s, logic en, int unsigned k);
        logic [EXT_W-1:0] v;
        v = {s.data, s.ext2};
        shift_step = s;
        {shift_step.data, shift_step.ext2} = en ? v >> k : v;
        shift_step.sticky = s.sticky | (en & (|(v & ((EXT_ONE << k) - EXT_ONE))));
    endfunction

    function automatic fin_t finish(stage_t s);
        finish = '{trunc: s.data, guard: s.ext2[1], sticky: s.ext2[0] | s.sticky, tag: s.tag};
    endfunction
endpackage

// File: rtl/shift_from_msb_denorm_if.sv
// shift_from_msb_denorm_if: operand/result handshake bundle of the denormalizer.
interface shift_from_msb_denorm_if;
    import shift_from_msb_denorm_pkg::*;
    logic in_valid, in_ready;
    logic [SIG_W-1:0] in_b;
    logic [SA_W-1:0] in_sa;
    logic [TAG_W-1:0] in_tag;
    logic out_valid, out_ready;
    logic [SIG_W-1:0] out_res, out_trunc;
    logic out_guard, out_sticky, out_inexact;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, in_b, in_sa, in_tag, out_ready,
        input in_ready, out_valid, out_res, out_trunc, out_guard, out_sticky, out_inexact, out_tag
    );
    modport slave (
        input in_valid, in_b, in_sa, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_trunc, out_guard, out_sticky, out_inexact, out_tag
    );
endinterface

// File: rtl/shift_from_msb_denorm_rnd.sv
// shift_rnd_rne: combinational round-to-nearest-even increment of a truncated significand.
module shift_rnd_rne
    import shift_from_msb_denorm_pkg::*;
(
    input logic [SIG_W-1:0] trunc,
    input logic guard,
    input logic sticky,
    input logic en,
    output logic [SIG_W-1:0] res
);
    assign res = trunc + SIG_W'(en & guard & (sticky | trunc[0]));
endmodule

// File: rtl/shift_from_msb_denorm.sv
// shift_from_msb_denorm: 3-stage right-shift denormalizer with guard/sticky and optional RNE rounding.
module shift_from_msb_denorm
    import shift_from_msb_denorm_pkg::*;
#(
    parameter bit RND_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    shift_from_msb_denorm_if.slave bus
);
    stage_t s0, p1_d, p1;
    fin_t p2_d, p2;
    logic v1, v2, v3, r1, r2, r3;
    logic [SIG_W-1:0] res;
    // Ready ripples back from the consumer; a stage may load whenever it is empty or its occupant moves on.
    assign r3 = ~v3 | bus.out_ready;
    assign r2 = ~v2 | r3;
    assign r1 = ~v1 | r2;
    assign bus.in_ready = r1;
    assign bus.out_valid = v3;
    assign s0 = '{data: bus.in_b, sa_rem: bus.in_sa[2:0], ext2: 2'b00, sticky: 1'b0, tag: bus.in_tag};
    assign p1_d = shift_step(shift_step(s0, bus.in_sa[4], 16), bus.in_sa[3], 8);
    assign p2_d = finish(shift_step(shift_step(shift_step(p1, p1.sa_rem[2], 4), p1.sa_rem[1], 2), p1.sa_rem[0], 1));
    shift_rnd_rne u_rnd (
        .trunc(p2.trunc),
        .guard(p2.guard),
        .sticky(p2.sticky),
        .en(RND_EN),
        .res(res)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, v3} <= '0;
            p1 <= '0;
            p2 <= '0;
            bus.out_res <= '0;
            bus.out_trunc <= '0;
            bus.out_guard <= 1'b0;
            bus.out_sticky <= 1'b0;
            bus.out_inexact <= 1'b0;
            bus.out_tag <= '0;
        end else begin
            if (r1) v1 <= bus.in_valid;
            if (r2) v2 <= v1;
            if (r3) v3 <= v2;
            if (r1 && bus.in_valid) p1 <= p1_d;
            if (r2 && v1) p2 <= p2_d;
            if (r3 && v2) begin
                bus.out_res <= res;
                bus.out_trunc <= p2.trunc;
                bus.out_guard <= p2.guard;
                bus.out_sticky <= p2.sticky;
                bus.out_inexact <= p2.guard | p2.sticky;
                bus.out_tag <= p2.tag;
            end
        end
    end
endmodule

// File: tb/tb_shift_from_msb_denorm.sv
// tb_shift_from_msb_denorm: directed checks of shifting, rounding, back-pressure, reset flush and round trip.
module tb_shift_from_msb_denorm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    shift_from_msb_denorm_if b0 ();
    shift_from_msb_denorm_if b1 ();
    shift_from_msb_denorm #(.RND_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(b0));
    shift_from_msb_denorm #(.RND_EN(1'b0)) dut_trunc (.clk(clk), .rst(rst), .bus(b1));
    assign b1.in_valid = b0.in_valid;
    assign b1.in_b = b0.in_b;
    assign b1.in_sa = b0.in_sa;
    assign b1.in_tag = b0.in_tag;
    assign b1.out_ready = b0.out_ready;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [23:0] b, input logic [4:0] sa, input logic [3:0] tag);
        bit acc = 1'b0;
        b0.in_valid = 1'b1;
        b0.in_b = b;
        b0.in_sa = sa;
        b0.in_tag = tag;
        for (int i = 0; i < 100 && !acc; i++) begin
            #1 acc = b0.in_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        chk("accept", 32'(acc), 1);
        @(negedge clk);
        b0.in_valid = 1'b0;
    endtask

    task automatic run(input string name, input logic [23:0] b, input logic [4:0] sa, input logic [3:0] tag,
                       input logic [23:0] er, input logic [23:0] et, input logic eg, input logic es,
                       input logic [23:0] er0);
        int lat = 1;
        send(b, sa, tag);
        while (!b0.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, 3);
        chk({name, " res"}, b0.out_res, er);
        chk({name, " trunc"}, b0.out_trunc, et);
        chk({name, " guard"}, b0.out_guard, eg);
        chk({name, " sticky"}, b0.out_sticky, es);
        chk({name, " inexact"}, b0.out_inexact, eg | es);
        chk({name, " tag"}, b0.out_tag, tag);
        chk({name, " res_trunc_mode"}, b1.out_res, er0);
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        b0.in_valid = 1'b0;
        b0.in_b = '0;
        b0.in_sa = '0;
        b0.in_tag = '0;
        b0.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst out_valid", b0.out_valid, 0);
        chk("rst out_res", b0.out_res, 0);
        chk("rst out_trunc", b0.out_trunc, 0);
        chk("rst flags", {b0.out_guard, b0.out_sticky, b0.out_inexact}, 0);
        chk("rst out_tag", b0.out_tag, 0);
        rst = 1'b0;
        #1 chk("rst in_ready", b0.in_ready, 1);
        @(negedge clk);

        run("b800000_s23", 24'h800000, 5'd23, 4'd1, 24'h000001, 24'h000001, 0, 0, 24'h000001);
        run("bC00000_s23", 24'hC00000, 5'd23, 4'd2, 24'h000002, 24'h000001, 1, 0, 24'h000001);
        run("bA00000_s23", 24'hA00000, 5'd23, 4'd3, 24'h000001, 24'h000001, 0, 1, 24'h000001);
        run("b800000_s24", 24'h800000, 5'd24, 4'd4, 24'h000000, 24'h000000, 1, 0, 24'h000000);
        run("b800001_s24", 24'h800001, 5'd24, 4'd5, 24'h000001, 24'h000000, 1, 1, 24'h000000);
        run("bFFFFFF_s31", 24'hFFFFFF, 5'd31, 4'd6, 24'h000000, 24'h000000, 0, 1, 24'h000000);
        run("bFFFFFF_s0", 24'hFFFFFF, 5'd0, 4'd7, 24'hFFFFFF, 24'hFFFFFF, 0, 0, 24'hFFFFFF);
        run("b000001_s25", 24'h000001, 5'd25, 4'd8, 24'h000000, 24'h000000, 0, 1, 24'h000000);
        run("b000003_s1", 24'h000003, 5'd1, 4'd9, 24'h000002, 24'h000001, 1, 0, 24'h000001);
        run("b000007_s2", 24'h000007, 5'd2, 4'd10, 24'h000002, 24'h000001, 1, 1, 24'h000001);
        run("b123456_s4", 24'h123456, 5'd4, 4'd11, 24'h012345, 24'h012345, 0, 1, 24'h012345);
        run("b5A5A5A_s12", 24'h5A5A5A, 5'd12, 4'd12, 24'h0005A6, 24'h0005A5, 1, 1, 24'h0005A5);

        fork
            begin
                for (int i = 0; i < 8; i++) send(24'(i + 1) << 4, 5'd4, 4'(i));
            end
            begin
                int n = 0;
                for (int c = 0; c < 60 && n < 8; c++) begin
                    b0.out_ready = !(c >= 4 && c < 9);
                    #1;
                    if (c == 8) begin
                        chk("stall in_ready", b0.in_ready, 0);
                        chk("stall out_valid", b0.out_valid, 1);
                    end
                    if (b0.out_valid && b0.out_ready) begin
                        chk("stream res", b0.out_res, n + 1);
                        chk("stream tag", b0.out_tag, n);
                        n++;
                    end
                    @(negedge clk);
                end
                chk("stream count", n, 8);
            end
        join
        b0.out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            seen |= b0.out_valid;
            @(negedge clk);
        end
        chk("stream no dup", 32'(seen), 0);

        send(24'h400000, 5'd2, 4'd13);
        send(24'h200000, 5'd1, 4'd14);
        rst = 1'b1;
        b0.in_valid = 1'b1;
        b0.in_b = 24'h100000;
        b0.in_sa = 5'd0;
        b0.in_tag = 4'd15;
        @(negedge clk);
        chk("flush out_valid", b0.out_valid, 0);
        chk("flush out_tag", b0.out_tag, 0);
        rst = 1'b0;
        b0.in_valid = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            seen |= b0.out_valid;
            @(negedge clk);
        end
        chk("flush nothing out", 32'(seen), 0);

        for (int i = 0; i < 16; i++) begin
            logic [23:0] a, nrm;
            int lz;
            a = 24'($urandom) >> $urandom_range(0, 23);
            if (a == 0) a = 24'd1;
            lz = 0;
            while (!a[23 - lz]) lz++;
            nrm = a << lz;
            run("roundtrip", nrm, 5'(lz), 4'(i), a, a, 0, 0, a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_from_msb_denorm.md
# shift_from_msb_denorm

Pipelined right-shift denormalizer: the inverse of the MSB-normalizing left shifter. It takes a 24-bit significand with the shift amount the normalizer produced, and shifts it back right. It yields the truncated result, guard and sticky bits, and a round-to-nearest-even result. It sits in the float→fixed and exponent-alignment paths of the quantization datapath, behind a valid/ready handshake.

## Interface
- TAG_W, 4, width of sideband tag carried alongside each operand (≥1)
- RND_EN, 1, 1 = `res` is RNE-rounded; 0 = `res` is truncated
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  operand present
- in_ready  out  1  operand accepted this cycle when in_valid & in_ready
- in_b  in  24  significand to shift right
- in_sa  in  5  right-shift amount, 0..31
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid & out_ready
- out_res  out  24  shifted result (rounded or truncated per RND_EN)
- out_trunc  out  24  truncated result, always available
- out_guard  out  1  last bit shifted out
- out_sticky  out  1  OR of all bits shifted out below guard
- out_inexact  out  1  out_guard | out_sticky
- out_tag  out  TAG_W  tag of this result

## Operation
- trunc = in_b >> in_sa; for sa ≥ 24, trunc = 0.
- guard = in_b[sa-1] for 1 ≤ sa ≤ 24; guard = 0 for sa = 0 or sa ≥ 25.
- sticky = |in_b[sa-2:0] for 2 ≤ sa ≤ 24; sticky = 0 for sa ≤ 1; sticky = |in_b for sa ≥ 25.
- RNE increments trunc when guard & (sticky | trunc[0]).
- The increment never carries out of 24 bits: sa ≥ 1 bounds trunc < 2^23, and sa = 0 gives guard = 0. No overflow flag is required.
- Shifter decomposition, mirroring the normalizer's stages:
  - S1: conditional shifts by 16 and 8, driven by sa[4] and sa[3].
  - S2: conditional shifts by 4, 2 and 1, driven by sa[2:0].
- Each stage accumulates the bits it discards into a running sticky. Guard and sticky are derived from a 2-bit extension carried below the LSB.
- Round-trip property: for any a ≠ 0, normalizing and then denormalizing with the returned sa reproduces a exactly, with inexact = 0.

## Timing
- Three register stages:
  - P1: after the 16/8 shift.
  - P2: after the 4/2/1 shift, with guard/sticky final.
  - P3: after rounding; these are the output registers.
- Latency is 3 cycles from the accept edge to out_valid, with no stall. Throughput is 1 operand per cycle.
- Each stage holds a valid bit vN. Stage N loads when ~vN | advance(N+1); advance(3) = out_ready.
- in_ready = ~v1 | advance(2). This is a combinational chain from out_ready; no skid buffer.
- Stage data is held stable while vN = 1 and the stage does not advance. out_* must not change while out_valid & ~out_ready.
- in_b, in_sa and in_tag are sampled only on accept. The shift amount travels with its operand through the stages.
- Reset: v1..v3 = 0, out_valid = 0, out_res = out_trunc = 0, out_guard = out_sticky = out_inexact = 0, out_tag = 0.
- in_ready = 1 in the first cycle after reset.
- rst asserted mid-operation discards all in-flight operands, with no partial output. An accept in a cycle where rst is high is ignored.
- Simultaneous accept and output consume with a full pipeline is allowed and must not drop or duplicate data.

## Structure
- Shared package holds:
  - SIG_W = 24 and SA_W = 5.
  - A packed stage struct {data, sa_remaining, ext2, sticky, tag}. Tag width comes via a parameterized wrapper, or TAG_W is fixed in the package.
- One sub-module is natural: `shift_rnd_rne`. It is a combinational RNE incrementer taking (trunc, guard, sticky, en) and producing res. It is reusable by the other rounding blocks.
- The pipeline control sits in the top level.

## Test plan
- in_b=0x800000, in_sa=23 → res=0x000001, guard=0, sticky=0, inexact=0, out_valid exactly 3 cycles after accept.
- in_b=0xC00000, sa=23 → trunc=0x000001, guard=1, sticky=0, res=0x000002 (tie, odd LSB rounds up); RND_EN=0 gives res=0x000001.
- in_b=0xA00000, sa=23 → trunc=1, guard=0, sticky=1, res=1, inexact=1. Also in_b=0x800000, sa=24 → res=0, guard=1, sticky=0 (tie to even → 0).
- in_b=0xFFFFFF, sa=31 → res=0, guard=0, sticky=1, inexact=1. Also sa=0 → res=0xFFFFFF, inexact=0.
- Back-to-back stream of 8 operands, out_ready held low for 5 cycles mid-stream:
  - in_ready drops once 3 results are held.
  - Results emerge in order with tags 0..7 intact, with no loss or duplication.
- Random a (nonzero) through the normalizer into this block → res == a, inexact=0. Assert rst while 2 operands are in flight → out_valid=0 the next cycle, and neither operand is ever output.
